// File: rtl/bf16_pkg.sv
// Shared BF16 constants and the types passed between the normalize and
// round/pack stages of the multiplier back end.
package bf16_pkg;

  localparam int         BF16_BIAS     = 127;
  localparam logic [7:0] BF16_EXP_MAX  = 8'hFF;
  localparam int         BF16_FRAC_W   = 7;

  // Packed BF16 word as it appears on the output bus.
  typedef struct packed {
    logic                   sign;
    logic [7:0]             exp;
    logic [BF16_FRAC_W-1:0] frac;
  } bf16_t;

  // Stage-1 register contents: an 8-bit significand with its leading one at
  // bit 7, the two rounding bits and a 10-bit signed exponent wide enough to
  // hold every out-of-range value without wrapping.
  typedef struct packed {
    logic              sign;
    logic              zero;
    logic              inf;
    logic signed [9:0] e;
    logic [7:0]        m;
    logic              guard;
    logic              sticky;
  } norm_t;

endpackage

// File: rtl/bf16_round_pack.sv
// Round-to-nearest-even on a normalized significand, then pack to BF16 with
// saturation to Inf on overflow and flush-to-zero on underflow.
module bf16_round_pack
  import bf16_pkg::*;
(
  input  norm_t norm,
  output bf16_t result
);

  // Smallest exponent that no longer fits the 8-bit biased field.
  localparam logic signed [9:0] E_OVF = 10'(2 * BF16_BIAS + 1);

  logic                   round_up;
  logic [8:0]             mr_sum;
  logic signed [9:0]      e_adj;
  logic [BF16_FRAC_W-1:0] frac;

  // Round, renormalize on carry-out, then select Inf / zero / normal encoding.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned, which would infer a latch.
    result   = '0;
    round_up = norm.guard && (norm.sticky || norm.m[0]);
    mr_sum   = {1'b0, norm.m} + {8'd0, round_up};

    // Rounding 0xFF up gives 0x100: the significand becomes 1.0 again and
    // the exponent absorbs the carry.
    if (mr_sum[8]) begin
      frac  = mr_sum[7:1];
      e_adj = norm.e + 10'sd1;
    end else begin
      frac  = mr_sum[6:0];
      e_adj = norm.e;
    end

    if (norm.inf || e_adj >= E_OVF) begin
      result = '{sign: norm.sign, exp: BF16_EXP_MAX, frac: '0};
    end else if (norm.zero || e_adj <= 10'sd0) begin
      result = '{sign: norm.sign, exp: '0, frac: '0};
    end else begin
      result = '{sign: norm.sign, exp: e_adj[7:0], frac: frac};
    end
  end

endmodule

// File: rtl/bf16_normalize_pack.sv
// BF16 multiplier back end: two-stage pipeline (normalize, round/pack) with a
// valid/ready handshake on each side and full one-per-cycle throughput.
module bf16_normalize_pack
  import bf16_pkg::*;
#(
  parameter int EXP_W  = 9,
  parameter int MANT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              prod_zero,
  input  logic              prod_inf,
  input  logic              prod_sign,
  input  logic [EXP_W-1:0]  prod_exp,
  input  logic [MANT_W-1:0] prod_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_bf16
);

  logic              s1_valid;
  logic              s2_valid;
  logic              adv1;
  logic              adv2;
  logic signed [9:0] exp_ext;
  norm_t             s1_d;
  norm_t             s1_q;
  bf16_t             s2_d;

  // A stage may load when it is empty or its content moves on this cycle, so
  // a full pipe still accepts one item while the result drains.
  assign adv2      = !s2_valid || out_ready;
  assign adv1      = !s1_valid || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  assign exp_ext = 10'($signed(prod_exp));

  // Normalize: the 8x8 product of 1.x significands has its leading one at
  // the top bit or the one below it.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = prod_sign;
    s1_d.zero = prod_zero;
    s1_d.inf  = prod_inf;
    if (prod_mant[MANT_W-1]) begin
      s1_d.m      = prod_mant[MANT_W-1 -: 8];
      s1_d.guard  = prod_mant[MANT_W-9];
      s1_d.sticky = |prod_mant[MANT_W-10:0];
      s1_d.e      = exp_ext + 10'sd1;
    end else begin
      s1_d.m      = prod_mant[MANT_W-2 -: 8];
      s1_d.guard  = prod_mant[MANT_W-10];
      s1_d.sticky = |prod_mant[MANT_W-11:0];
      s1_d.e      = exp_ext;
    end
  end

  // Stage-1 occupancy; reset drops any in-flight item.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
    end
  end

  // Stage-1 payload, captured only on an actual transfer.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; the valid bit alone decides
    // whether their contents mean anything.
    if (adv1 && in_valid) begin
      s1_q <= s1_d;
    end
  end

  bf16_round_pack u_round_pack (
    .norm   (s1_q),
    .result (s2_d)
  );

  // Output register: holds its word while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_bf16 <= 16'h0000;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_bf16 <= s2_d;
      end
    end
  end

endmodule

// File: tb/tb_bf16_normalize_pack.sv
// Bench for bf16_normalize_pack: directed corner cases, backpressure, reset
// while busy, and a randomized stream checked against an arithmetic model.
module tb_bf16_normalize_pack;

  localparam int N_RANDOM   = 10000;
  localparam int RAND_LIMIT = 60000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        prod_zero;
  logic        prod_inf;
  logic        prod_sign;
  logic [8:0]  prod_exp;
  logic [15:0] prod_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_bf16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf16_normalize_pack #(.EXP_W(9), .MANT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod_zero (prod_zero),
    .prod_inf  (prod_inf),
    .prod_sign (prod_sign),
    .prod_exp  (prod_exp),
    .prod_mant (prod_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bf16  (out_bf16)
  );

  // Reference: value = mant * 2^(pe-127-14). Keep 8 significant bits, round
  // the discarded remainder to nearest-even, then saturate or flush.
  function automatic logic [15:0] ref_pack(input logic sign, input logic zero,
                                           input logic inf, input int pe,
                                           input int mant);
    int p, ue, shift, q, rem, half;
    if (inf) return {sign, 8'hFF, 7'h00};
    p     = (mant >= 32768) ? 15 : 14;
    ue    = pe + p - 14;
    shift = p - 7;
    q     = mant >> shift;
    rem   = mant - (q << shift);
    half  = 1 << (shift - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == 256) begin
      q  = 128;
      ue = ue + 1;
    end
    if (ue >= 255) return {sign, 8'hFF, 7'h00};
    if (zero || ue <= 0) return {sign, 15'h0000};
    return {sign, ue[7:0], q[6:0]};
  endfunction

  task automatic drive_idle();
    in_valid  = 1'b0;
    prod_sign = 1'b0;
    prod_zero = 1'b0;
    prod_inf  = 1'b0;
    prod_exp  = '0;
    prod_mant = '0;
  endtask

  task automatic set_in(input logic s, input logic z, input logic i,
                        input int pe, input int mant);
    in_valid  = 1'b1;
    prod_sign = s;
    prod_zero = z;
    prod_inf  = i;
    prod_exp  = pe[8:0];
    prod_mant = mant[15:0];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_vec++;
    if (out_bf16 !== 16'h0000) begin
      n_err++; $display("FAIL reset_out_bf16: got %h expected 0000", out_bf16);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    // {sign, zero, inf}, exponent, mantissa, expected word
    logic [2:0]  flg_t [14] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                                3'b110, 3'b101, 3'b100, 3'b000, 3'b000, 3'b100, 3'b000};
    int          pe_t  [14] = '{127, 127, 127, 127, 127, 254, 0, 127, 127, -5, 254, 0, 127, 253};
    int          man_t [14] = '{'h4000, 'h9000, 'h8280, 'h8B80, 'h7FF9, 'h8000, 'h4000,
                                'h0000, 'h4000, 'h4000, 'h4000, 'h8000, 'hC000, 'hFF80};
    logic [15:0] exp_t [14] = '{16'h3F80, 16'h4010, 16'h4002, 16'h400C, 16'h4000, 16'h7F80,
                                16'h0000, 16'h8000, 16'hFF80, 16'h8000, 16'h7F00, 16'h0080,
                                16'hC040, 16'h7F80};
    for (int k = 0; k < 14; k++) begin
      out_ready = 1'b1;
      set_in(flg_t[k][2], flg_t[k][1], flg_t[k][0], pe_t[k], man_t[k]);
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", k, in_ready);
      end
      @(posedge clk);
      #1 drive_idle();
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL directed_early[%0d]: out_valid got %b expected 0", k, out_valid);
      end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_bf16 !== exp_t[k]) begin
        n_err++;
        $display("FAIL directed[%0d]: got valid=%b word=%h expected valid=1 word=%h",
                 k, out_valid, out_bf16, exp_t[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int          man_t [4] = '{'h4000, 'h9000, 'h8B80, 'h7FF9};
    int          pe_t  [4] = '{100, 101, 102, 103};
    logic [15:0] exp_q[$];
    logic [15:0] e;
    logic [15:0] prev_val = '0;
    logic        prev_stall = 1'b0;
    logic        saw_block = 1'b0;
    logic        exp_ready;
    int          sent = 0;
    int          got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) set_in(1'b0, 1'b0, 1'b0, pe_t[sent], man_t[sent]);
      else drive_idle();
      out_ready = (cyc >= 5);
      @(negedge clk);
      exp_ready = ((sent - got) < 2) || out_ready;
      n_vec++;
      if (in_ready !== exp_ready) begin
        n_err++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ready);
      end
      if (in_ready === 1'b0) saw_block = 1'b1;
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_bf16 !== prev_val) begin
          n_err++;
          $display("FAIL b2b_hold cyc %0d: got valid=%b word=%h expected valid=1 word=%h",
                   cyc, out_valid, out_bf16, prev_val);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_pack(1'b0, 1'b0, 1'b0, pe_t[sent], man_t[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL b2b_extra: got word=%h expected no result", out_bf16);
        end else begin
          e = exp_q.pop_front();
          if (out_bf16 !== e) begin
            n_err++; $display("FAIL b2b_order[%0d]: got %h expected %h", got, out_bf16, e);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = out_bf16;
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (got != 4 || !saw_block) begin
      n_err++; $display("FAIL b2b_count: got %0d results blocked=%b expected 4 blocked=1", got, saw_block);
    end
    drive_idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL b2b_dup: out_valid got %b expected 0", out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_c;
    exp_c = ref_pack(1'b1, 1'b0, 1'b0, 130, 'h9000);
    out_ready = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 127, 'h4000);
    @(posedge clk);
    #1 set_in(1'b0, 1'b0, 1'b0, 127, 'h9000);
    @(posedge clk);
    #1 drive_idle();
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_busy: out_valid got %b expected 1", out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 130, 'h9000);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rstmid_flush: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 drive_idle();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_gap: out_valid got %b expected 0", out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_bf16 !== exp_c) begin
      n_err++; $display("FAIL rstmid_next: got valid=%b word=%h expected valid=1 word=%h", out_valid, out_bf16, exp_c);
    end
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_alone: out_valid got %b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    logic [15:0] e;
    logic [15:0] prev_val = '0;
    logic        prev_stall = 1'b0;
    logic        exp_ready;
    logic        have = 1'b0;
    logic        c_s, c_z, c_i;
    int          c_pe, c_m, ea, eb, ma, mb, kind;
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    while (got < N_RANDOM && cyc < RAND_LIMIT) begin
      if (!have && sent < N_RANDOM) begin
        kind = $urandom_range(0, 31);
        ea   = $urandom_range(1, 254);
        eb   = $urandom_range(1, 254);
        ma   = $urandom_range(0, 127);
        mb   = $urandom_range(0, 127);
        c_s  = 1'($urandom_range(0, 1));
        c_z  = (kind == 0);
        c_i  = (kind == 1);
        if (c_z) ea = 0;
        if (c_i) ea = 255;
        c_pe = ea + eb - 127;
        if (c_pe > 255) c_pe = 255;
        c_m  = c_z ? 0 : (128 + ma) * (128 + mb);
        have = 1'b1;
      end
      if (have && $urandom_range(0, 4) != 0) set_in(c_s, c_z, c_i, c_pe, c_m);
      else drive_idle();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_ready = ((sent - got) < 2) || out_ready;
      n_vec++;
      if (in_ready !== exp_ready) begin
        n_err++; $display("FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_ready);
      end
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_bf16 !== prev_val) begin
          n_err++;
          $display("FAIL rand_hold cyc %0d: got valid=%b word=%h expected valid=1 word=%h",
                   cyc, out_valid, out_bf16, prev_val);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_pack(c_s, c_z, c_i, c_pe, c_m));
        sent++;
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL rand_extra: got word=%h expected no result", out_bf16);
        end else begin
          e = exp_q.pop_front();
          if (out_bf16 !== e) begin
            n_err++; $display("FAIL rand_result[%0d]: got %h expected %h", got, out_bf16, e);
          end
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_val   = out_bf16;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_vec++;
    if (got != N_RANDOM) begin
      n_err++; $display("FAIL rand_count: got %0d results expected %0d", got, N_RANDOM);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
